// File: rtl/ecg_sample_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ecg_sample_framer_if
//  Description : Bundles the framer's byte-input, sample-output and status
//                signals.
//                master : framer side. It takes in the UART bytes and the
//                         downstream ready, and drives samples and status.
//                slave  : environment side. It drives the UART bytes and
//                         sample_ready.
//  Signals     : rx_data[7:0], rx_ready, sample_data[15:0], sample_valid,
//                sample_ready, fifo_level[$clog2(FIFO_DEPTH):0], overflow,
//                frame_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface ecg_sample_framer_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [7:0]                    rx_data;
    logic                          rx_ready;
    logic [15:0]                   sample_data;
    logic                          sample_valid;
    logic                          sample_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic                          frame_err;

    modport master (
        input  rx_data, rx_ready, sample_ready,
        output sample_data, sample_valid, fifo_level, overflow, frame_err
    );

    modport slave (
        output rx_data, rx_ready, sample_ready,
        input  sample_data, sample_valid, fifo_level, overflow, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ecg_sample_framer.sv
`default_nettype none
// ============================================================================
//  Module      : ecg_sample_framer
//  Description : Turns the UART byte stream into framed 16-bit signed ECG
//                samples.
//                Frame layout: SYNC_BYTE, sample[15:8], sample[7:0].
//                With checksum enabled, a fourth check byte follows.
//                Completed samples go into a show-ahead FIFO. The filter
//                reads them over a valid/ready handshake.
//  Ports       : Clk, Rst       - clock, synchronous active-high reset
//                bus (master)   - rx_data/rx_ready in; sample_data,
//                                 sample_valid, fifo_level, overflow,
//                                 frame_err out; sample_ready in
//  Options     : FRAMER_CHECKSUM_EN - when defined, enables the 4th byte
//                (hi ^ lo ^ SYNC_BYTE). A mismatch drops the sample and
//                pulses frame_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module ecg_sample_framer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         FIFO_DEPTH     = 8,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  wire logic           Clk,
    input  wire logic           Rst,
    ecg_sample_framer_if.master bus
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_HUNT, S_MSB, S_LSB, S_CHK} state_t;

    state_t                r_state;
    logic [c_TW-1:0]       r_tmo_cnt;
    logic [7:0]            r_hi;
`ifdef FRAMER_CHECKSUM_EN
    logic [7:0]            r_lo;
`endif
    logic                  r_frame_err;
    logic                  r_overflow;
    logic [15:0]           r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_LW-1:0]       r_level;

    state_t                w_state_eff;
    logic                  w_timeout;
    logic                  w_push;
    logic                  w_chk_bad;
    logic [15:0]           w_push_data;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push_ok;

    // A timeout behaves as if the FSM were already back in HUNT this cycle.
    // So a byte that arrives in the same cycle is treated as a hunt byte.
    always_comb begin
        w_timeout   = 1'b0;
        w_push      = 1'b0;
        w_chk_bad   = 1'b0;
        w_push_data = {r_hi, bus.rx_data};
        if (TIMEOUT_CYCLES != 0 && r_state != S_HUNT &&
            r_tmo_cnt == c_TW'(TIMEOUT_CYCLES)) begin
            w_timeout = 1'b1;
        end
        w_state_eff = w_timeout ? S_HUNT : r_state;
        if (bus.rx_ready) begin
`ifdef FRAMER_CHECKSUM_EN
            w_push_data = {r_hi, r_lo};
            if (w_state_eff == S_CHK) begin
                if (bus.rx_data == (r_hi ^ r_lo ^ SYNC_BYTE)) begin
                    w_push = 1'b1;
                end else begin
                    w_chk_bad = 1'b1;
                end
            end
`else
            if (w_state_eff == S_LSB) begin
                w_push = 1'b1;
            end
`endif
        end
    end

    // Frame FSM and inter-byte timeout counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= S_HUNT;
            r_tmo_cnt   <= '0;
            r_hi        <= '0;
`ifdef FRAMER_CHECKSUM_EN
            r_lo        <= '0;
`endif
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_timeout | w_chk_bad;
            if (bus.rx_ready || w_state_eff == S_HUNT) begin
                r_tmo_cnt <= '0;
            end else if (TIMEOUT_CYCLES != 0) begin
                r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
            end
            r_state <= w_state_eff;
            if (bus.rx_ready) begin
                case (w_state_eff)
                    S_HUNT: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            r_state <= S_MSB;
                        end
                    end
                    S_MSB: begin
                        r_hi    <= bus.rx_data;
                        r_state <= S_LSB;
                    end
                    S_LSB: begin
`ifdef FRAMER_CHECKSUM_EN
                        r_lo    <= bus.rx_data;
                        r_state <= S_CHK;
`else
                        r_state <= S_HUNT;
`endif
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    // Show-ahead sample FIFO. A pop frees a slot in the same cycle, so a
    // push into a full FIFO succeeds when a pop happens alongside it.
    assign w_pop     = (r_level != '0) && bus.sample_ready;
    assign w_full    = (r_level == c_LW'(FIFO_DEPTH));
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge Clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The output is forced to zero when the FIFO is empty, so that stale
    // RAM contents never appear on sample_data.
    assign bus.sample_data  = (r_level != '0) ? r_mem[r_rd_ptr] : 16'h0000;
    assign bus.sample_valid = (r_level != '0);
    assign bus.fifo_level   = r_level;
    assign bus.overflow     = r_overflow;
    assign bus.frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ecg_sample_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecg_sample_framer
//  Description : Self-checking bench for ecg_sample_framer. It uses a
//                scoreboard queue of expected samples, plus directed checks
//                of reset, timeout, overflow and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ecg_sample_framer;
    localparam int c_DEPTH = 8;
    localparam int c_TO    = 50;
    localparam logic [7:0] c_SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ecg_sample_framer_if #(.FIFO_DEPTH(c_DEPTH)) bus ();

    ecg_sample_framer #(
        .SYNC_BYTE(c_SYNC), .FIFO_DEPTH(c_DEPTH), .TIMEOUT_CYCLES(c_TO)
    ) u_dut (
        .Clk(clk), .Rst(rst), .bus(bus.master)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_ferr   = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare every accepted head against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_err) n_ferr++;
            if (bus.sample_valid && bus.sample_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 32'(bus.sample_data), 32'hFFFF_FFFF);
                end else begin
                    check("sample_data", 32'(bus.sample_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit pulse_rdy = 1'b0);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        if (pulse_rdy) bus.sample_ready = 1'b1;
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
        if (pulse_rdy) bus.sample_ready = 1'b0;
    endtask

    // Sends a full frame; `expect_it` queues the sample as a future output.
    task automatic send_frame(input logic [15:0] s, input bit expect_it, input bit pulse_rdy = 1'b0);
        logic [7:0] hi, lo;
        hi = s[15:8];
        lo = s[7:0];
        if (expect_it) exp_q.push_back(s);
        send_byte(c_SYNC);
        send_byte(hi);
`ifdef FRAMER_CHECKSUM_EN
        send_byte(lo);
        send_byte(hi ^ lo ^ c_SYNC, pulse_rdy);
`else
        send_byte(lo, pulse_rdy);
`endif
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.sample_valid) break;
        end
        check({tag, "_q"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_lvl"}, 32'(bus.fifo_level), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int  ferr0;
        bit  seen;
        int  wait_cyc;
        bus.rx_data      = 8'h00;
        bus.rx_ready     = 1'b0;
        bus.sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_data", 32'(bus.sample_data), 32'd0);

        // 1: basic frame; valid one cycle after the last byte strobe
        bus.sample_ready = 1'b1;
        exp_q.push_back(16'h1234);
        send_byte(8'hA5);
        send_byte(8'h12);
`ifdef FRAMER_CHECKSUM_EN
        send_byte(8'h34);
        send_byte(8'h12 ^ 8'h34 ^ c_SYNC);
`else
        send_byte(8'h34);
`endif
        @(negedge clk);
        check("t1_valid", 32'(bus.sample_valid), 32'd1);
        wait_drain("t1");

        // 2: junk bytes ignored, sync byte inside data, negative sample
        send_byte(8'h00);
        send_byte(8'h7F);
        send_frame(16'hFF38, 1'b1);
        send_frame(16'hA5A5, 1'b1);
        wait_drain("t2");

        // 3: timeout mid-frame
        ferr0 = n_ferr;
        send_byte(8'hA5);
        send_byte(8'h80);
        seen = 1'b0;
        wait_cyc = 0;
        for (int i = 0; i < 4 * c_TO; i++) begin
            @(negedge clk);
            if (bus.frame_err) begin
                seen = 1'b1;
                wait_cyc = i;
                break;
            end
        end
        check("t3_ferr_seen", 32'(seen), 32'd1);
        check("t3_not_early", 32'(wait_cyc >= c_TO), 32'd1);
        @(negedge clk);
        check("t3_ferr_1cyc", 32'(bus.frame_err), 32'd0);
        check("t3_ferr_count", 32'(n_ferr - ferr0), 32'd1);
        send_frame(16'h0001, 1'b1);
        wait_drain("t3");

        // 4a: overflow with the sink stalled
        bus.sample_ready = 1'b0;
        for (int k = 0; k <= c_DEPTH; k++) begin
            send_frame(16'h1000 + 16'(k), k < c_DEPTH);
        end
        @(negedge clk);
        check("t4_level", 32'(bus.fifo_level), 32'(c_DEPTH));
        check("t4_ovf", 32'(bus.overflow), 32'd1);
        check("t4_head", 32'(bus.sample_data), 32'h1000);
        bus.sample_ready = 1'b1;
        wait_drain("t4a");
        check("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

        // 4b: a pop on the final push cycle frees room, so no overflow occurs
        bus.sample_ready = 1'b0;
        do_reset();
        @(negedge clk);
        check("t4b_ovf_clr", 32'(bus.overflow), 32'd0);
        for (int k = 0; k <= c_DEPTH; k++) begin
            send_frame(16'h2000 + 16'(k), 1'b1, k == c_DEPTH);
        end
        @(negedge clk);
        check("t4b_level", 32'(bus.fifo_level), 32'(c_DEPTH));
        check("t4b_ovf", 32'(bus.overflow), 32'd0);
        bus.sample_ready = 1'b1;
        wait_drain("t4b");

        // 5: reset mid-frame discards the partial sample
        send_byte(8'hA5);
        send_byte(8'h12);
        do_reset();
        @(negedge clk);
        check("t5_valid", 32'(bus.sample_valid), 32'd0);
        check("t5_ovf", 32'(bus.overflow), 32'd0);
        send_byte(8'h34);
        send_frame(16'h5678, 1'b1);
        wait_drain("t5");

`ifdef FRAMER_CHECKSUM_EN
        // 6: a bad check byte drops the sample and pulses frame_err
        ferr0 = n_ferr;
        send_frame(16'h1234, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check("t6_ferr_count", 32'(n_ferr - ferr0), 32'd1);
        wait_drain("t6");
`endif

        repeat (5) @(negedge clk);
        check("end_no_ferr", 32'(bus.frame_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
